vecmat32_sched: RTL

//  Sequencer for the 32-lane signed vec-mat datapath (32 multipliers + adder tree, 512b operands, 16b result).

---
 rtl/vecmat_pkg.sv | 24 ++
 rtl/vecmat_res_fifo.sv | 77 +++++++
 rtl/vecmat32_sched.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/vecmat_pkg.sv
// Shared definitions for the vec-mat scheduler and its result FIFO.
//   LANES/LANEW/VECW : operand geometry of the 32-lane signed datapath
//   state_e          : scheduler FSM states
//   res_t            : one collected result (dot product + column index)
package vecmat_pkg;

    localparam int LANES    = 32;
    localparam int LANEW    = 16;
    localparam int VECW     = LANES * LANEW;
    localparam int RES_COLW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [LANEW-1:0]    data;
        logic [RES_COLW-1:0] idx;
    } res_t;

endpackage

// File: rtl/vecmat_res_fifo.sv
// Registered show-ahead result FIFO.
//   clk, reset     : clock, synchronous active-low reset (clears pointers, count, storage)
//   push/push_data : write one entry
//   pop            : consume the head entry (ignored when empty)
//   head_data      : current head entry, held stable until popped
//   not_empty      : head_data is valid
//   count          : number of stored entries (0..DEPTH)
// Push and pop in the same cycle are allowed even when full: the head is read
// combinationally from storage before the write slot (== head slot) is overwritten.
module vecmat_res_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 24,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             not_empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign not_empty = (count_q != '0);
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && not_empty;
        // A push into a full FIFO is only accepted when a pop frees the slot.
        push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vecmat32_sched.sv
// Sequencer for the 32-lane signed vec-mat datapath (softmax-vector x V).
//   clk, reset            : clock, synchronous active-low reset (aborts any job, no done pulse)
//   start/num_cols/base_addr/vec_in : job request, sampled only in IDLE
//   busy                  : job in progress (ISSUE or DRAIN)
//   done                  : one-cycle pulse at job end (also for a zero-column job)
//   mat_rd_en/mat_addr    : column-RAM read port, data returns RD_LAT cycles later
//   mat_rdata             : column data, forwarded as dp_matrix
//   dp_vector/dp_matrix   : datapath operands, dp_result returns DP_LAT cycles later
//   res_valid/res_ready/res_data/res_idx : result stream, valid/ready handshake
// Handshake: a result transfers in every cycle where res_valid & res_ready are both
// high; while res_valid is high and res_ready low, res_data/res_idx hold their value.
// Issue is credit-gated: a read is only issued while reads in flight plus buffered
// results stay below FIFO_DEPTH, so a stalled consumer can never overflow the FIFO.
// Sustained rate is therefore bounded by FIFO_DEPTH over the issue-to-pop loop latency.
module vecmat32_sched
    import vecmat_pkg::*;
#(
    parameter int DP_LAT     = 3,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int COLW       = 8,
    parameter int AW         = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [COLW-1:0] num_cols,
    input  logic [AW-1:0]   base_addr,
    input  logic [VECW-1:0] vec_in,
    output logic            busy,
    output logic            done,
    output logic            mat_rd_en,
    output logic [AW-1:0]   mat_addr,
    input  logic [VECW-1:0] mat_rdata,
    output logic [VECW-1:0] dp_vector,
    output logic [VECW-1:0] dp_matrix,
    input  logic [LANEW-1:0] dp_result,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [LANEW-1:0] res_data,
    output logic [COLW-1:0] res_idx
);

    localparam int PIPE = RD_LAT + DP_LAT;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int RESW = LANEW + COLW;

    state_e          state_q, state_d;
    logic [VECW-1:0] vec_q, vec_d;
    logic [AW-1:0]   base_q, base_d;
    logic [COLW-1:0] ncols_q, ncols_d;
    logic [COLW-1:0] issue_cnt_q, issue_cnt_d;
    logic            mat_rd_en_q, mat_rd_en_d;
    logic [AW-1:0]   mat_addr_q, mat_addr_d;
    logic [COLW-1:0] rd_idx_q, rd_idx_d;
    logic [PIPE-1:0] vld_q, vld_d;
    logic [COLW-1:0] pidx_q [PIPE];
    logic [COLW-1:0] pidx_d [PIPE];
    logic [CW-1:0]   inflight_q, inflight_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            issue;
    logic            credit_ok;
    logic [CW:0]     occupancy;
    logic            push;
    logic            pop;
    logic [RESW-1:0] push_word;
    logic [RESW-1:0] head_word;
    logic            fifo_valid;
    logic [CW-1:0]   fifo_count;

    // Results are pushed when the tail of the valid pipe lines up with dp_result.
    assign push      = vld_q[PIPE-1];
    assign push_word = {dp_result, pidx_q[PIPE-1]};
    assign pop       = fifo_valid && res_ready;

    assign occupancy = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign credit_ok = (occupancy < (CW+1)'(FIFO_DEPTH));

    vecmat_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RESW)
    ) u_res_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head_data (head_word),
        .not_empty (fifo_valid),
        .count     (fifo_count)
    );

    assign res_valid = fifo_valid;
    assign res_data  = head_word[RESW-1:COLW];
    assign res_idx   = head_word[COLW-1:0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign mat_rd_en = mat_rd_en_q;
    assign mat_addr  = mat_addr_q;
    assign dp_vector = vec_q;
    assign dp_matrix = mat_rdata;

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        base_d      = base_q;
        ncols_d     = ncols_q;
        issue_cnt_d = issue_cnt_q;
        issue       = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_cols != '0) begin
                        vec_d       = vec_in;
                        base_d      = base_addr;
                        ncols_d     = num_cols;
                        issue_cnt_d = '0;
                        state_d     = ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue       = 1'b1;
                    issue_cnt_d = issue_cnt_q + COLW'(1);
                    if (issue_cnt_q == ncols_q - COLW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave as the last buffered result is consumed so done lands
                // the cycle right after that final pop.
                if ((inflight_q == '0) &&
                    ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop))) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ISSUE) || (state_d == DRAIN);
    end

    // Read port, valid pipe and credit accounting.
    always_comb begin
        mat_rd_en_d = issue;
        mat_addr_d  = mat_addr_q;
        rd_idx_d    = rd_idx_q;
        if (issue) begin
            // AW-bit add wraps modulo 2^AW by construction.
            mat_addr_d = base_q + AW'(issue_cnt_q);
            rd_idx_d   = issue_cnt_q;
        end

        vld_d[0]  = mat_rd_en_q;
        pidx_d[0] = rd_idx_q;
        for (int k = 1; k < PIPE; k++) begin
            vld_d[k]  = vld_q[k-1];
            pidx_d[k] = pidx_q[k-1];
        end

        case ({issue, push})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            base_q      <= '0;
            ncols_q     <= '0;
            issue_cnt_q <= '0;
            mat_rd_en_q <= 1'b0;
            mat_addr_q  <= '0;
            rd_idx_q    <= '0;
            vld_q       <= '0;
            for (int k = 0; k < PIPE; k++) begin
                pidx_q[k] <= '0;
            end
            inflight_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            base_q      <= base_d;
            ncols_q     <= ncols_d;
            issue_cnt_q <= issue_cnt_d;
            mat_rd_en_q <= mat_rd_en_d;
            mat_addr_q  <= mat_addr_d;
            rd_idx_q    <= rd_idx_d;
            vld_q       <= vld_d;
            pidx_q      <= pidx_d;
            inflight_q  <= inflight_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule
